// File: rtl/reg_map_param.sv
// rtl/reg_map_param.sv - parametrised RW/RO/W1C register map for the I2C slave datapath
//
// Purpose: NUM_REGS registers of DATA_W bits. Each register is read/write,
// read-only status (two-flop synchronised status_in), or sticky
// write-1-to-clear event (rising edges of event_in). Writes commit on the
// falling edge of wr_en_wdata.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   addr, wdata  - register address and write data, sampled at the commit edge
//   wr_en_wdata  - write strobe; the write commits on its falling edge
//   rdata        - combinational read data for addr (0 when out of range)
//   regs_out     - flat view of all registers, register i at [i*DATA_W +: DATA_W]
//   status_in    - status inputs feeding read-only registers
//   event_in     - event inputs feeding W1C registers, rising-edge sensitive
//   irq          - registered OR of all W1C register bits
//   wr_err       - one-cycle pulse after a write to an absent or read-only register
module reg_map_param #(
    parameter int                            NUM_REGS  = 8,
    parameter int                            DATA_W    = 8,
    parameter int                            ADDR_W    = 8,
    parameter logic [NUM_REGS-1:0]           RO_MASK   = '0,
    parameter logic [NUM_REGS-1:0]           W1C_MASK  = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]    RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic                         wr_en_wdata,
    output logic [DATA_W-1:0]            rdata,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    input  logic [NUM_REGS*DATA_W-1:0]   status_in,
    input  logic [NUM_REGS*DATA_W-1:0]   event_in,
    output logic                         irq,
    output logic                         wr_err
);

    if ((RO_MASK & W1C_MASK) != '0) begin : g_bad_masks
        $error("reg_map_param: RO_MASK and W1C_MASK overlap");
    end
    if (NUM_REGS < 1 || NUM_REGS > (1 << ADDR_W)) begin : g_bad_num_regs
        $error("reg_map_param: NUM_REGS outside 1..2**ADDR_W");
    end

    // One extra bit so NUM_REGS = 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] NUM_REGS_A = (ADDR_W+1)'(NUM_REGS);

    logic                hold;
    logic                fedge;
    logic                addr_ok;
    logic [NUM_REGS-1:0] wr_sel;
    logic [NUM_REGS-1:0] w1c_nz;
    logic                wr_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= 1'b0;
        end else begin
            hold <= wr_en_wdata;
        end
    end

    assign fedge   = hold & ~wr_en_wdata;
    assign addr_ok = ({1'b0, addr} < NUM_REGS_A);

    // Out-of-range address or a read-only target both count as illegal.
    assign wr_bad = (fedge & ~addr_ok) | (|(wr_sel & RO_MASK));

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam int LSB = i * DATA_W;
        logic [DATA_W-1:0] q;

        assign wr_sel[i] = fedge & (addr == ADDR_W'(i));

        if (RO_MASK[i]) begin : g_ro
            logic [DATA_W-1:0] sync1;
            logic              unused_ev;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1 <= '0;
                    q     <= '0;
                end else begin
                    sync1 <= status_in[LSB +: DATA_W];
                    q     <= sync1;
                end
            end

            assign unused_ev = ^event_in[LSB +: DATA_W];
            assign w1c_nz[i] = 1'b0;
        end else if (W1C_MASK[i]) begin : g_w1c
            logic [DATA_W-1:0] ev_d;
            logic [DATA_W-1:0] rise;
            logic [DATA_W-1:0] clr;
            logic              unused_st;

            assign rise = event_in[LSB +: DATA_W] & ~ev_d;
            assign clr  = wr_sel[i] ? wdata : '0;

            // Set beats clear when both hit a bit on the same edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ev_d <= '0;
                    q    <= '0;
                end else begin
                    ev_d <= event_in[LSB +: DATA_W];
                    q    <= (q & ~clr) | rise;
                end
            end

            assign unused_st = ^status_in[LSB +: DATA_W];
            assign w1c_nz[i] = |q;
        end else begin : g_rw
            logic unused_in;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q <= RESET_VAL[LSB +: DATA_W];
                end else if (wr_sel[i]) begin
                    q <= wdata;
                end
            end

            assign unused_in = ^{status_in[LSB +: DATA_W], event_in[LSB +: DATA_W]};
            assign w1c_nz[i] = 1'b0;
        end

        assign regs_out[LSB +: DATA_W] = q;
    end

    // Compare-and-select mux: never forms an index from addr, so an
    // out-of-range address simply matches nothing and reads 0.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_W'(i)) begin
                rdata = regs_out[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq    <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            irq    <= |w1c_nz;
            wr_err <= wr_bad;
        end
    end

endmodule

// File: tb/tb_reg_map_param.sv
// tb/tb_reg_map_param.sv - self-checking bench for reg_map_param
module tb_reg_map_param;

    localparam int               NR          = 8;
    localparam logic [7:0]       RO_MASK_P   = 8'b0101_0000;
    localparam logic [7:0]       W1C_MASK_P  = 8'b0010_1000;
    localparam logic [63:0]      RESET_VAL_P = 64'h0000_0000_00A5_0000;

    logic        clk;
    logic        rst;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic        wr_en_wdata;
    logic [7:0]  rdata;
    logic [63:0] regs_out;
    logic [63:0] status_in;
    logic [63:0] event_in;
    logic        irq;
    logic        wr_err;

    int checks   = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    reg_map_param #(
        .NUM_REGS (NR),
        .DATA_W   (8),
        .ADDR_W   (8),
        .RO_MASK  (RO_MASK_P),
        .W1C_MASK (W1C_MASK_P),
        .RESET_VAL(RESET_VAL_P)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wdata      (wdata),
        .wr_en_wdata(wr_en_wdata),
        .rdata      (rdata),
        .regs_out   (regs_out),
        .status_in  (status_in),
        .event_in   (event_in),
        .irq        (irq),
        .wr_err     (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Behavioural model: register contents from the rules, with the status
    // path as "last edge's sample" and events as "now high, previously low".
    logic [7:0]  m_reg [NR];
    logic [7:0]  m_stat_prev [NR];
    logic [63:0] m_ev_prev;
    logic        m_prev_strobe;
    logic        m_irq;
    logic        m_err;
    logic        m_commit;
    logic [7:0]  m_rise;
    logic [7:0]  m_clr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                m_reg[i]       = (RO_MASK_P[i] || W1C_MASK_P[i]) ? 8'h00 : RESET_VAL_P[i*8 +: 8];
                m_stat_prev[i] = 8'h00;
            end
            m_ev_prev     = '0;
            m_prev_strobe = 1'b0;
            m_irq         = 1'b0;
            m_err         = 1'b0;
        end else begin
            m_commit = m_prev_strobe && !wr_en_wdata;
            m_irq = 1'b0;
            for (int i = 0; i < NR; i++)
                if (W1C_MASK_P[i] && m_reg[i] != 8'h00) m_irq = 1'b1;
            m_err = m_commit && (addr >= NR || RO_MASK_P[addr[2:0]]);
            for (int i = 0; i < NR; i++) begin
                if (RO_MASK_P[i]) begin
                    m_reg[i]       = m_stat_prev[i];
                    m_stat_prev[i] = status_in[i*8 +: 8];
                end else if (W1C_MASK_P[i]) begin
                    m_rise   = event_in[i*8 +: 8] & ~m_ev_prev[i*8 +: 8];
                    m_clr    = (m_commit && addr == i) ? wdata : 8'h00;
                    m_reg[i] = (m_reg[i] & ~m_clr) | m_rise;
                end else if (m_commit && addr == i) begin
                    m_reg[i] = wdata;
                end
            end
            m_ev_prev     = event_in;
            m_prev_strobe = wr_en_wdata;
        end
    end

    function automatic logic [63:0] model_flat();
        logic [63:0] f;
        for (int i = 0; i < NR; i++) f[i*8 +: 8] = m_reg[i];
        return f;
    endfunction

    function automatic logic [7:0] model_rdata();
        return (addr < NR) ? m_reg[addr[2:0]] : 8'h00;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("rdata", {56'h0, rdata}, {56'h0, model_rdata()});
            check("regs_out", regs_out, model_flat());
            check("irq", {63'h0, irq}, {63'h0, m_irq});
            check("wr_err", {63'h0, wr_err}, {63'h0, m_err});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        addr = 8'h00;
        wdata = 8'h00;
        wr_en_wdata = 1'b0;
        status_in = '0;
        event_in = '0;
        tick();
        tick();
        cmp_en = 1'b1;
        rst = 1'b0;
        addr = 8'h02;
        tick();
        #1;
        check("reset_rdata_a2", {56'h0, rdata}, 64'hA5);
        check("reset_regs", regs_out, 64'h0000_0000_00A5_0000);
        check("reset_irq", {63'h0, irq}, 64'h0);

        // RW write, strobe high three cycles.
        addr = 8'h01; wdata = 8'h3C; wr_en_wdata = 1'b1;
        tick(); tick(); tick();
        check("rw_no_write_while_high", {56'h0, regs_out[15:8]}, 64'h00);
        wr_en_wdata = 1'b0;
        tick();
        check("rw_commit", {56'h0, regs_out[15:8]}, 64'h3C);
        check("rw_no_err", {63'h0, wr_err}, 64'h0);
        wdata = 8'h77;
        tick();
        check("rw_single_write", {56'h0, regs_out[15:8]}, 64'h3C);

        // Out-of-range write.
        addr = 8'h08; wdata = 8'hFF; wr_en_wdata = 1'b1;
        tick();
        wr_en_wdata = 1'b0;
        tick();
        check("oor_err", {63'h0, wr_err}, 64'h1);
        check("oor_rdata", {56'h0, rdata}, 64'h0);
        check("oor_regs", regs_out, 64'h0000_0000_00A5_3C00);
        tick();
        check("oor_err_one_cycle", {63'h0, wr_err}, 64'h0);

        // RO write.
        addr = 8'h04; wr_en_wdata = 1'b1;
        tick();
        wr_en_wdata = 1'b0;
        tick();
        check("ro_err", {63'h0, wr_err}, 64'h1);
        check("ro_unchanged", {56'h0, regs_out[39:32]}, 64'h0);
        tick();

        // Status latency.
        status_in[39:32] = 8'h5A;
        tick();
        check("ro_not_yet", {56'h0, regs_out[39:32]}, 64'h0);
        tick();
        check("ro_visible", {56'h0, rdata}, 64'h5A);

        // W1C events and clears.
        event_in[47:40] = 8'h81;
        tick();
        check("w1c_set", {56'h0, regs_out[47:40]}, 64'h81);
        event_in = '0;
        tick();
        check("w1c_irq", {63'h0, irq}, 64'h1);
        addr = 8'h05; wdata = 8'h01; wr_en_wdata = 1'b1;
        tick();
        wr_en_wdata = 1'b0;
        tick();
        check("w1c_clr01", {56'h0, regs_out[47:40]}, 64'h80);
        check("w1c_irq_stays", {63'h0, irq}, 64'h1);
        wdata = 8'h80; wr_en_wdata = 1'b1;
        tick();
        wr_en_wdata = 1'b0;
        tick();
        check("w1c_clr80", {56'h0, regs_out[47:40]}, 64'h00);
        tick();
        check("w1c_irq_drop", {63'h0, irq}, 64'h0);

        // Set and clear on the same edge: set wins.
        wdata = 8'h08; wr_en_wdata = 1'b1;
        tick();
        wr_en_wdata = 1'b0;
        event_in[47:40] = 8'h08;
        tick();
        check("w1c_set_wins", {56'h0, regs_out[47:40]}, 64'h08);
        event_in = '0;
        tick();

        // Back-to-back strobes on register 0.
        addr = 8'h00; wdata = 8'h11; wr_en_wdata = 1'b1;
        tick();
        wr_en_wdata = 1'b0;
        tick();
        check("b2b_first", {56'h0, regs_out[7:0]}, 64'h11);
        wdata = 8'h22; wr_en_wdata = 1'b1;
        tick();
        wr_en_wdata = 1'b0;
        tick();
        check("b2b_second", {56'h0, regs_out[7:0]}, 64'h22);

        // Last legal address.
        addr = 8'h07; wdata = 8'hC3; wr_en_wdata = 1'b1;
        tick();
        wr_en_wdata = 1'b0;
        tick();
        check("last_addr", {56'h0, regs_out[63:56]}, 64'hC3);
        check("last_addr_no_err", {63'h0, wr_err}, 64'h0);

        // Reset mid-strobe.
        status_in = '0;
        addr = 8'h01; wdata = 8'hEE; wr_en_wdata = 1'b1;
        tick();
        #1 rst = 1'b1;
        #1;
        check("mid_rst_regs", regs_out, 64'h0000_0000_00A5_0000);
        check("mid_rst_irq", {63'h0, irq}, 64'h0);
        check("mid_rst_err", {63'h0, wr_err}, 64'h0);
        wr_en_wdata = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_no_write", {56'h0, regs_out[15:8]}, 64'h00);
        check("post_rst_no_err", {63'h0, wr_err}, 64'h0);

        // Randomised phase, checked by the per-cycle compare process.
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            wr_en_wdata = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) addr = 8'($urandom_range(0, 9));
            wdata = 8'($urandom);
            event_in = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) status_in = {$urandom, $urandom};
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
